// File: rtl/pipelined_add_sub_unit.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal slices.
// Each rank sums one slice, and the whole pipe shifts or holds on a single advance signal.
module pipelined_add_sub_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4   // WIDTH must be a multiple of STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_rank
    localparam int LO   = gi * SEG;
    localparam int REM  = WIDTH - LO;   // operand bits not yet summed on entry to this rank
    localparam int DONE = LO + SEG;     // result bits held by this rank

    logic            valid_in;
    logic            carry_in;
    logic [REM-1:0]  op_a;
    logic [REM-1:0]  op_b;
    logic [SEG:0]    slice_sum;
    logic [DONE-1:0] s_next;
    logic            valid_reg;
    logic            carry_reg;
    logic [DONE-1:0] s_reg;

    if (gi == 0) begin : g_head
      assign valid_in = in_valid;
      assign op_a     = a;
      assign op_b     = sub ? ~b : b;
      assign carry_in = sub | c_in;
      assign s_next   = slice_sum[SEG-1:0];
    end else begin : g_tail
      assign valid_in = g_rank[gi-1].valid_reg;
      assign op_a     = g_rank[gi-1].g_fwd.a_rem_reg;
      assign op_b     = g_rank[gi-1].g_fwd.b_rem_reg;
      assign carry_in = g_rank[gi-1].carry_reg;
      assign s_next   = {slice_sum[SEG-1:0], g_rank[gi-1].s_reg};
    end

    assign slice_sum = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]} + (SEG+1)'(carry_in);

    // Data only loads with a valid op, so bubbles leave the last result in place.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        s_reg     <= '0;
      end else if (adv) begin
        valid_reg <= valid_in;
        if (valid_in) begin
          carry_reg <= slice_sum[SEG];
          s_reg     <= s_next;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_rem_reg;
      logic [REM-SEG-1:0] b_rem_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_rem_reg <= '0;
          b_rem_reg <= '0;
        end else if (adv && valid_in) begin
          a_rem_reg <= op_a[REM-1:SEG];
          b_rem_reg <= op_b[REM-1:SEG];
        end
      end
    end else begin : g_flags
      // The last slice carries the operand MSBs, so the flags are formed here.
      logic ovf_reg;
      logic zero_reg;
      logic neg_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_reg  <= 1'b0;
          zero_reg <= 1'b0;
          neg_reg  <= 1'b0;
        end else if (adv && valid_in) begin
          ovf_reg  <= (op_a[SEG-1] == op_b[SEG-1]) && (slice_sum[SEG-1] != op_a[SEG-1]);
          zero_reg <= (s_next == '0);
          neg_reg  <= slice_sum[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_rank[STAGES-1].valid_reg;
  assign s         = g_rank[STAGES-1].s_reg;
  assign c_out     = g_rank[STAGES-1].carry_reg;
  assign ovf       = g_rank[STAGES-1].g_flags.ovf_reg;
  assign zero      = g_rank[STAGES-1].g_flags.zero_reg;
  assign neg       = g_rank[STAGES-1].g_flags.neg_reg;

endmodule

// File: tb/tb_pipelined_add_sub_unit.sv
// Directed bench for pipelined_add_sub_unit: STAGES=4, 1 and 32 instances share stimulus.
// Covers results, flags, latency, back-pressure ordering and reset discard.
module tb_pipelined_add_sub_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         c_in;
  logic         sub;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         c_out_w     [3];
  logic         ovf_w       [3];
  logic         zero_w      [3];
  logic         neg_w       [3];
  logic [W-1:0] s_w         [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_add_sub_unit #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .s(s_w[0]), .c_out(c_out_w[0]), .ovf(ovf_w[0]),
    .zero(zero_w[0]), .neg(neg_w[0])
  );

  pipelined_add_sub_unit #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .s(s_w[1]), .c_out(c_out_w[1]), .ovf(ovf_w[1]),
    .zero(zero_w[1]), .neg(neg_w[1])
  );

  pipelined_add_sub_unit #(.WIDTH(W), .STAGES(32)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .s(s_w[2]), .c_out(c_out_w[2]), .ovf(ovf_w[2]),
    .zero(zero_w[2]), .neg(neg_w[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated op; the result of each instance is captured on its out_valid pulse.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez, input logic en,
                        input bit all_inst);
    logic [W-1:0] got_s [3];
    logic         got_c [3];
    logic         got_o, got_z, got_n;
    int           lat   [3];
    bit           seen  [3];
    int           exp_lat [3];
    exp_lat = '{3, 0, 31};
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0; lat[k] = -1; got_s[k] = 'x; got_c[k] = 1'bx;
    end
    got_o = 1'bx; got_z = 1'bx; got_n = 1'bx;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (out_valid_w[k] && !seen[k]) begin
          seen[k] = 1'b1; lat[k] = n; got_s[k] = s_w[k]; got_c[k] = c_out_w[k];
          if (k == 0) begin
            got_o = ovf_w[0]; got_z = zero_w[0]; got_n = neg_w[0];
          end
        end
      end
    end
    check({tag, "_s4_valid"}, 64'(seen[0]), 64'd1);
    check({tag, "_s4_lat"}, 64'(lat[0]), 64'(exp_lat[0]));
    check({tag, "_s4_s"}, 64'(got_s[0]), 64'(es));
    check({tag, "_s4_cout"}, 64'(got_c[0]), 64'(ec));
    check({tag, "_s4_ovf"}, 64'(got_o), 64'(eo));
    check({tag, "_s4_zero"}, 64'(got_z), 64'(ez));
    check({tag, "_s4_neg"}, 64'(got_n), 64'(en));
    $display("op %s a=%h b=%h sub=%0b -> s=%h c_out=%0b lat=%0d", tag, ta, tb_v, ts, got_s[0], got_c[0], lat[0]);
    if (all_inst) begin
      for (int k = 1; k < 3; k++) begin
        string nm;
        nm = (k == 1) ? "_s1" : "_s32";
        check({tag, nm, "_valid"}, 64'(seen[k]), 64'd1);
        check({tag, nm, "_lat"}, 64'(lat[k]), 64'(exp_lat[k]));
        check({tag, nm, "_s"}, 64'(got_s[k]), 64'(es));
        check({tag, nm, "_cout"}, 64'(got_c[k]), 64'(ec));
      end
    end
  endtask

  logic [W-1:0] bp_a [6] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
  logic [W-1:0] bp_b [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
  logic [W-1:0] bp_s [6] = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 32'd66};

  initial begin
    int  sent;
    int  recv;
    bit  extra;
    bit  rst_seen;

    reset = 1'b1; in_valid = 1'b0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("rst_s", 64'(s_w[0]), 64'd0);
    check("rst_zero", 64'(zero_w[0]), 64'd0);
    check("rst_in_ready", 64'(in_ready_w[0]), 64'd1);
    $display("reset released: out_valid=%0b s=%h in_ready=%0b", out_valid_w[0], s_w[0], in_ready_w[0]);

    //      tag        a             b             cin   sub   s             c     ovf   zero  neg   all
    run_op("add_ff",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("add_cin",  32'hFFFFFFFF, 32'hFFFFFAFF, 1'b1, 1'b0, 32'hFFFFFAFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("add_dec",  32'd1092657,  32'd1534,     1'b0, 1'b0, 32'd1094191,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_pos",  32'd12,       32'd10,       1'b1, 1'b1, 32'd2,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",  32'd3,        32'd4,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_zero", 32'd5,        32'd5,        1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_add",  32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub",  32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-pressure: consumer stalls, then drains; results must come out once each, in order.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 9);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        a = bp_a[sent]; b = bp_b[sent]; c_in = 1'b0; sub = 1'b0;
      end
      #1;
      if (out_valid_w[0] && recv < 6) begin
        check("bp_s", 64'(s_w[0]), 64'(bp_s[recv]));
        if (!out_ready) check("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
        $display("bp cyc=%0d out_ready=%0b s=%0d in_ready=%0b", cyc, out_ready, s_w[0], in_ready_w[0]);
      end
      if (in_valid && in_ready_w[0]) sent++;
      if (out_valid_w[0] && out_ready) recv++;
    end
    check("bp_sent", 64'(sent), 64'd6);
    check("bp_recv", 64'(recv), 64'd6);
    @(negedge clk);
    in_valid = 1'b0;
    extra = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid_w[0]) extra = 1'b1;
    end
    check("bp_no_dup", 64'(extra), 64'd0);

    // Reset one edge after accept, with another op offered on the reset edge.
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1; a = 32'h0000FFFF; b = 32'h00000001;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst2_s", 64'(s_w[0]), 64'd0);
    check("rst2_cout", 64'(c_out_w[0]), 64'd0);
    check("rst2_ovf", 64'(ovf_w[0]), 64'd0);
    check("rst2_neg", 64'(neg_w[0]), 64'd0);
    rst_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid_w[0]) rst_seen = 1'b1;
      @(negedge clk);
    end
    check("rst2_no_valid", 64'(rst_seen), 64'd0);
    $display("reset discard: out_valid seen=%0b s=%h", rst_seen, s_w[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
